// File: rtl/mc_pkg.sv
// mc_pkg
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode constants, ALU/PC mux select codes, the bundled control-word
// struct and small state classification helpers.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12,
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR      = 2'b01;
    localparam logic [1:0] SRC_B_IMM       = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHIFT = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that sit waiting on the memory handshake and are timed.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    // Last state of every instruction; leaving one of these retires it.
    function automatic logic is_completion_state(input state_t s);
        return (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_R_WB) ||
               (s == ST_BRANCH) || (s == ST_JUMP) || (s == ST_I_WB);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer
// Counts consecutive stalled cycles spent in a memory-wait state and flags
// the cycle on which the stall budget runs out.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset
//   clear   - restart the count (the controller is changing state)
//   stall   - this cycle is a stalled wait cycle
//   timeout - this stalled cycle is the last one allowed
module mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    localparam int LIMIT = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int W     = $clog2(LIMIT + 1);

    logic [W-1:0] wait_cnt;

    // The count restarts on every state change, so it always measures how
    // long the current wait state has been stalling; it only advances on
    // stalled cycles so a frozen controller freezes the count as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The LIMIT-th stalled cycle is the one that gives up.
    assign timeout = stall && (wait_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM for a multi-cycle MIPS subset (R-type, lw, sw, beq, j, addi)
// with a memory handshake, stall timeout, sticky fault/illegal flags and
// cycle/instruction counters.
// Ports:
//   SYS_clk, SYS_reset      - clock, synchronous active-high reset
//   run_en                  - advance enable; 0 freezes the controller
//   OpCode                  - instruction[31:26] from the instruction register
//   zero                    - ALU zero flag (combined with pc_write_cond in the datapath)
//   mem_ready               - memory handshake complete
//   pc_write .. pc_source   - datapath control word for the current state
//   state_out               - encoded current state
//   fault, illegal          - sticky memory-timeout and bad-opcode flags
//   cycle_count, instr_count - free-running activity counters
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter bit EN_ADDI     = 1'b1
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             run_en,
    input  logic [5:0]       OpCode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state_out,
    output logic             fault,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   illegal_hit;
    logic   timeout;
    logic   wait_stall;
    logic   timer_clear;
    logic   unused_zero;

    assign unused_zero = zero;

    assign wait_stall  = run_en && is_wait_state(state) && !mem_ready;
    assign timer_clear = run_en && (state_next != state);

    mc_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (SYS_clk),
        .reset   (SYS_reset),
        .clear   (timer_clear),
        .stall   (wait_stall),
        .timeout (timeout)
    );

    // Next-state selection. Nothing moves while run_en is low. Wait states
    // leave on mem_ready or fall into FAULT when the timer expires; decode
    // steers by opcode and any unsupported opcode lands in FAULT with the
    // illegal flag. MEM_ADDR re-reads the opcode (still held in the IR) to
    // pick the read or write path.
    always_comb begin
        state_next  = state;
        illegal_hit = 1'b0;
        if (run_en) begin
            case (state)
                ST_IDLE:   state_next = ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready)    state_next = ST_DECODE;
                    else if (timeout) state_next = ST_FAULT;
                end
                ST_DECODE: begin
                    case (OpCode)
                        OP_RTYPE:     state_next = ST_R_EXEC;
                        OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                        OP_BEQ:       state_next = ST_BRANCH;
                        OP_J:         state_next = ST_JUMP;
                        OP_ADDI: begin
                            if (EN_ADDI) begin
                                state_next = ST_I_EXEC;
                            end else begin
                                state_next  = ST_FAULT;
                                illegal_hit = 1'b1;
                            end
                        end
                        default: begin
                            state_next  = ST_FAULT;
                            illegal_hit = 1'b1;
                        end
                    endcase
                end
                ST_MEM_ADDR: begin
                    if (OpCode == OP_LW) begin
                        state_next = ST_MEM_RD;
                    end else if (OpCode == OP_SW) begin
                        state_next = ST_MEM_WR;
                    end else begin
                        state_next  = ST_FAULT;
                        illegal_hit = 1'b1;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready)    state_next = ST_MEM_WB;
                    else if (timeout) state_next = ST_FAULT;
                end
                ST_MEM_WR: begin
                    if (mem_ready)    state_next = ST_FETCH;
                    else if (timeout) state_next = ST_FAULT;
                end
                ST_MEM_WB: state_next = ST_FETCH;
                ST_R_EXEC: state_next = ST_R_WB;
                ST_R_WB:   state_next = ST_FETCH;
                ST_BRANCH: state_next = ST_FETCH;
                ST_JUMP:   state_next = ST_FETCH;
                ST_I_EXEC: state_next = ST_I_WB;
                ST_I_WB:   state_next = ST_FETCH;
                ST_FAULT:  state_next = ST_FAULT;
                default:   state_next = ST_FAULT;
            endcase
        end
    end

    // State register, sticky flags and counters. Reset wins over everything.
    // An instruction retires when a completion state hands back to FETCH;
    // cycles are counted only while the machine is actually running a
    // program (not idle, not dead in FAULT).
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state       <= ST_IDLE;
            fault       <= 1'b0;
            illegal     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else if (run_en) begin
            state <= state_next;
            if (timeout) begin
                fault <= 1'b1;
            end
            if (illegal_hit) begin
                illegal <= 1'b1;
            end
            if ((state != ST_IDLE) && (state != ST_FAULT)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if ((state_next == ST_FETCH) && is_completion_state(state)) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    // Moore control word per state. The only exception is FETCH, where the
    // IR and PC update strobes wait for mem_ready so the fetched word is
    // captured exactly once. With run_en low every write strobe is killed
    // while selects and mem_req keep their state value.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SHIFT;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR, ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            default: ctrl = '0;
        endcase
        if (!run_en) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.mem_we        = 1'b0;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign iord          = ctrl.iord;
    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state_out     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl: a hand-written vector table,
// directed multi-cycle corner sequences and a randomized run, all compared
// against an instruction-level reference model kept in this file.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    logic        SYS_clk;
    logic        SYS_reset;
    logic        run_en;
    logic [5:0]  OpCode;
    logic        zero;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_out;
    logic        fault, illegal;
    logic [31:0] cycle_count, instr_count;

    logic        d2_pc_write, d2_pc_write_cond, d2_ir_write, d2_iord, d2_mem_req, d2_mem_we;
    logic        d2_reg_write, d2_reg_dst, d2_mem_to_reg, d2_alu_src_a;
    logic [1:0]  d2_alu_src_b, d2_alu_op, d2_pc_source;
    logic [3:0]  d2_state_out;
    logic        d2_fault, d2_illegal;
    logic [3:0]  d2_cycle_count, d2_instr_count;

    logic [15:0] ctrl1;
    assign ctrl1 = {pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we,
                    reg_write, reg_dst, mem_to_reg, alu_src_a,
                    alu_src_b, alu_op, pc_source};

    multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO), .EN_ADDI(1'b1)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .run_en(run_en), .OpCode(OpCode),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state_out(state_out), .fault(fault), .illegal(illegal),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .EN_ADDI(1'b0)) dut2 (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .run_en(run_en), .OpCode(OpCode),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(d2_pc_write), .pc_write_cond(d2_pc_write_cond), .ir_write(d2_ir_write),
        .iord(d2_iord), .mem_req(d2_mem_req), .mem_we(d2_mem_we), .reg_write(d2_reg_write),
        .reg_dst(d2_reg_dst), .mem_to_reg(d2_mem_to_reg), .alu_src_a(d2_alu_src_a),
        .alu_src_b(d2_alu_src_b), .alu_op(d2_alu_op), .pc_source(d2_pc_source),
        .state_out(d2_state_out), .fault(d2_fault), .illegal(d2_illegal),
        .cycle_count(d2_cycle_count), .instr_count(d2_instr_count)
    );

    // Free-running clock, 10 time units per period.
    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the phase sequence of the instruction in
    // flight, the stall budget and the architectural counters.
    int          m_state;
    int          m_wait;
    bit          m_fault, m_illegal;
    logic [31:0] m_cycles, m_instrs;
    int          plan[$];

    logic [3:0]  s_state;
    logic [15:0] s_ctrl;
    logic [31:0] s_instr;

    typedef struct {
        bit         rst;
        bit         run;
        logic [5:0] op;
        bit         rdy;
        int         st;
        logic [15:0] ctrl;
        int         instr;
    } vec_t;
    vec_t tbl[$];

    task automatic addVec(input bit rst, input bit run, input logic [5:0] op, input bit rdy,
                          input int st, input logic [15:0] ctrl, input int instr);
        vec_t v;
        v.rst = rst; v.run = run; v.op = op; v.rdy = rdy;
        v.st = st; v.ctrl = ctrl; v.instr = instr;
        tbl.push_back(v);
    endtask

    // Control word bit order: pcw pcwc irw iord mreq mwe rw rdst m2r asa asb[2] aop[2] psrc[2]
    function automatic logic [15:0] expCtrl(input int st, input bit run, input bit rdy);
        logic [15:0] c;
        case (st)
            1:       c = rdy ? 16'hA810 : 16'h0810;
            2:       c = 16'h0030;
            3:       c = 16'h0060;
            4:       c = 16'h1800;
            5:       c = 16'h0280;
            6:       c = 16'h1C00;
            7:       c = 16'h0048;
            8:       c = 16'h0300;
            9:       c = 16'h4045;
            10:      c = 16'h8002;
            11:      c = 16'h0060;
            12:      c = 16'h0200;
            default: c = 16'h0000;
        endcase
        if (!run) c = c & ~16'hE600;
        return c;
    endfunction

    function automatic void modelReset();
        m_state = 0; m_wait = 0; m_fault = 0; m_illegal = 0;
        m_cycles = 0; m_instrs = 0;
        plan.delete();
    endfunction

    function automatic int advance();
        if (m_state == 1) return 2;
        if (plan.size() > 0) return plan.pop_front();
        m_instrs = m_instrs + 1;
        return 1;
    endfunction

    function automatic void modelStep();
        int nxt;
        if (SYS_reset) begin
            modelReset();
        end else if (run_en) begin
            nxt = m_state;
            if (m_state != 0 && m_state != 15) m_cycles = m_cycles + 1;
            case (m_state)
                0:  nxt = 1;
                15: nxt = 15;
                1, 4, 6: begin
                    if (mem_ready) nxt = advance();
                    else if (m_wait + 1 >= TO) begin nxt = 15; m_fault = 1; end
                    else m_wait = m_wait + 1;
                end
                2: begin
                    plan.delete();
                    case (OpCode)
                        6'h00:   plan = '{7, 8};
                        6'h23:   plan = '{3, 4, 5};
                        6'h2B:   plan = '{3, 6};
                        6'h04:   plan = '{9};
                        6'h02:   plan = '{10};
                        6'h08:   plan = '{11, 12};
                        default: m_illegal = 1;
                    endcase
                    if (plan.size() == 0) nxt = 15;
                    else nxt = plan.pop_front();
                end
                default: nxt = advance();
            endcase
            if (nxt != m_state) m_wait = 0;
            m_state = nxt;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("ctrl", {48'd0, ctrl1}, {48'd0, expCtrl(m_state, run_en, mem_ready)});
        checkOutput("state", {60'd0, state_out}, 64'(m_state));
        checkOutput("flags", {62'd0, fault, illegal}, {62'd0, m_fault, m_illegal});
        checkOutput("counters", {cycle_count, instr_count}, {m_cycles, m_instrs});
    endtask

    // Drive one cycle: inputs settle, outputs are compared at the falling
    // edge, the model advances on the rising edge.
    task automatic applyStimulus(input bit rst, input bit run, input logic [5:0] op, input bit rdy);
        SYS_reset = rst; run_en = run; OpCode = op; mem_ready = rdy;
        zero = 1'($urandom_range(0, 1));
        @(negedge SYS_clk);
        s_state = state_out; s_ctrl = ctrl1; s_instr = instr_count;
        checkModel();
        @(posedge SYS_clk);
        modelStep();
        #1;
    endtask

    function automatic logic [5:0] pickOp();
        int r;
        r = $urandom_range(0, 13);
        case (r)
            0, 1:    return 6'h00;
            2, 3:    return 6'h23;
            4, 5:    return 6'h2B;
            6, 7:    return 6'h04;
            8, 9:    return 6'h02;
            10, 11:  return 6'h08;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    // Main test sequence: table, directed corner cases, then random run.
    initial begin
        int cnt;
        int stalls;
        int fault_cycles;
        bit rst_r;
        logic [5:0] cur_op;

        SYS_reset = 1'b1; run_en = 1'b0; OpCode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge SYS_clk);
        #1;
        modelReset();

        addVec(1, 1, 6'h00, 1, 0,  16'h0000, 0);
        addVec(0, 1, 6'h00, 0, 0,  16'h0000, 0);
        addVec(0, 1, 6'h00, 1, 1,  16'hA810, 0);
        addVec(0, 1, 6'h00, 0, 2,  16'h0030, 0);
        addVec(0, 1, 6'h00, 1, 7,  16'h0048, 0);
        addVec(0, 1, 6'h00, 0, 8,  16'h0300, 0);
        addVec(0, 1, 6'h04, 0, 1,  16'h0810, 1);
        addVec(0, 1, 6'h04, 1, 1,  16'hA810, 1);
        addVec(0, 1, 6'h04, 0, 2,  16'h0030, 1);
        addVec(0, 1, 6'h04, 0, 9,  16'h4045, 1);
        addVec(0, 1, 6'h02, 1, 1,  16'hA810, 2);
        addVec(0, 1, 6'h02, 0, 2,  16'h0030, 2);
        addVec(0, 1, 6'h02, 0, 10, 16'h8002, 2);
        addVec(0, 1, 6'h2B, 1, 1,  16'hA810, 3);
        addVec(0, 1, 6'h2B, 0, 2,  16'h0030, 3);
        addVec(0, 1, 6'h2B, 0, 3,  16'h0060, 3);
        addVec(0, 1, 6'h2B, 0, 6,  16'h1C00, 3);
        addVec(0, 0, 6'h2B, 1, 6,  16'h1800, 3);
        addVec(0, 1, 6'h2B, 1, 6,  16'h1C00, 3);
        addVec(0, 1, 6'h08, 1, 1,  16'hA810, 4);
        addVec(0, 1, 6'h08, 0, 2,  16'h0030, 4);
        addVec(0, 1, 6'h08, 0, 11, 16'h0060, 4);
        addVec(0, 1, 6'h08, 0, 12, 16'h0200, 4);
        addVec(0, 1, 6'h23, 1, 1,  16'hA810, 5);
        addVec(0, 1, 6'h23, 0, 2,  16'h0030, 5);
        addVec(0, 1, 6'h23, 0, 3,  16'h0060, 5);
        addVec(0, 1, 6'h23, 1, 4,  16'h1800, 5);
        addVec(0, 1, 6'h23, 0, 5,  16'h0280, 5);
        addVec(0, 1, 6'h00, 0, 1,  16'h0810, 6);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].rdy);
            checkOutput($sformatf("tbl_state[%0d]", i), {60'd0, s_state}, 64'(tbl[i].st));
            checkOutput($sformatf("tbl_ctrl[%0d]", i), {48'd0, s_ctrl}, {48'd0, tbl[i].ctrl});
            checkOutput($sformatf("tbl_instr[%0d]", i), {32'd0, s_instr}, 64'(tbl[i].instr));
        end

        // lw with mem_ready held off for three cycles in MEM_RD.
        applyStimulus(0, 1, 6'h23, 1);
        applyStimulus(0, 1, 6'h23, 0);
        applyStimulus(0, 1, 6'h23, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (state_out == 4'd4) cnt++;
            applyStimulus(0, 1, 6'h23, k == 3);
        end
        checkOutput("lw_rd_cycles", 64'(cnt), 64'd4);
        checkOutput("lw_wb_state", {60'd0, state_out}, 64'd5);
        checkOutput("lw_wb_m2r_fault", {62'd0, mem_to_reg, fault}, 64'b10);

        // Freeze for five cycles in R_EXEC, then reset mid-instruction.
        applyStimulus(0, 1, 6'h00, 0);
        applyStimulus(0, 1, 6'h00, 1);
        applyStimulus(0, 1, 6'h00, 0);
        checkOutput("hold_enter_rexec", {60'd0, state_out}, 64'd7);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 6'h00, 1);
        checkOutput("hold_state", {60'd0, state_out}, 64'd7);
        checkOutput("hold_cycles", {32'd0, cycle_count}, {32'd0, m_cycles});
        applyStimulus(1, 1, 6'h00, 1);
        checkOutput("rst_state", {60'd0, state_out}, 64'd0);
        checkOutput("rst_counts", {cycle_count, instr_count}, 64'd0);
        checkOutput("rst_flags", {62'd0, fault, illegal}, 64'd0);

        // FETCH starved of mem_ready until the stall budget runs out.
        applyStimulus(0, 1, 6'h00, 0);
        cnt = 0;
        stalls = 0;
        while (stalls < 40 && state_out != 4'd15) begin
            if (state_out == 4'd1) cnt++;
            applyStimulus(0, 1, 6'h00, 0);
            stalls++;
            if (stalls == 3) checkOutput("d2_pre_timeout", {60'd0, d2_state_out}, 64'd1);
            if (stalls == 4) checkOutput("d2_timeout", {59'd0, d2_state_out, d2_fault}, {59'd0, 4'd15, 1'b1});
        end
        checkOutput("timeout_wait_cycles", 64'(cnt), 64'd15);
        checkOutput("timeout_flags", {58'd0, state_out, fault, illegal}, {58'd0, 4'd15, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 6'h00, 1);
        checkOutput("fault_absorb", {44'd0, state_out, ctrl1}, {44'd0, 4'd15, 16'h0000});
        applyStimulus(1, 1, 6'h00, 0);

        // Unknown opcode lands in FAULT with only the illegal flag.
        applyStimulus(0, 1, 6'h3F, 0);
        applyStimulus(0, 1, 6'h3F, 1);
        applyStimulus(0, 1, 6'h3F, 0);
        checkOutput("illegal_flags", {58'd0, state_out, illegal, fault}, {58'd0, 4'd15, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 6'h00, 1);
        checkOutput("illegal_absorb", {44'd0, state_out, ctrl1}, {44'd0, 4'd15, 16'h0000});
        applyStimulus(1, 1, 6'h00, 0);

        // Five R-type instructions: 20 counted cycles wrap a 4-bit counter to 4.
        applyStimulus(0, 1, 6'h00, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 6'h00, 1);
            applyStimulus(0, 1, 6'h00, 0);
            applyStimulus(0, 1, 6'h00, 0);
            applyStimulus(0, 1, 6'h00, 0);
        end
        checkOutput("d2_cycle_wrap", {60'd0, d2_cycle_count}, 64'd4);
        checkOutput("d2_instr", {60'd0, d2_instr_count}, 64'd5);
        applyStimulus(0, 1, 6'h08, 1);
        applyStimulus(0, 1, 6'h08, 0);
        checkOutput("addi_enabled", {60'd0, state_out}, 64'd11);
        checkOutput("addi_disabled", {58'd0, d2_state_out, d2_illegal, d2_fault}, {58'd0, 4'd15, 1'b1, 1'b0});
        applyStimulus(0, 1, 6'h08, 0);

        // Randomized run against the reference model.
        applyStimulus(1, 1, 6'h00, 0);
        fault_cycles = 0;
        cur_op = 6'h00;
        for (int n = 0; n < 1500; n++) begin
            if (m_state == 15) fault_cycles++;
            else fault_cycles = 0;
            rst_r = ($urandom_range(0, 299) == 0) || (fault_cycles > 3);
            if (m_state == 1) cur_op = pickOp();
            applyStimulus(rst_r, $urandom_range(0, 9) != 0, cur_op, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameters: CNT_W, 32, width of cycle/instruction counters; MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before fault; EN_ADDI, 1, 1 = decode addi (001000), 0 = treat it as illegal.
REQ-002 SHALL have ports, one clock, reset synchronous active-high: SYS_clk in 1 clock; SYS_reset in 1 sync active-high reset; run_en in 1 advance enable (0 = hold state); OpCode in 6 instruction[31:26] from the instruction register; zero in 1 ALU zero flag; mem_ready in 1 memory handshake done; pc_write out 1; pc_write_cond out 1; ir_write out 1; iord out 1 (0 = PC address, 1 = ALU address); mem_req out 1; mem_we out 1; reg_write out 1; reg_dst out 1; mem_to_reg out 1; alu_src_a out 1; alu_src_b out 2; alu_op out 2; pc_source out 2; state_out out 4 encoded state; fault out 1 sticky; illegal out 1 sticky; cycle_count out CNT_W; instr_count out CNT_W.

Function
REQ-003 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, FAULT=15; state_out = current state.
REQ-004 SHALL transition IDLE->FETCH on first cycle with run_en=1.
REQ-005 FETCH: mem_req=1, iord=0; stay until mem_ready=1; on that cycle ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, go to DECODE.
REQ-006 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by OpCode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->I_EXEC if EN_ADDI=1; any other->FAULT with illegal=1.
REQ-007 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; ->MEM_RD if lw, ->MEM_WR if sw.
REQ-008 MEM_RD: mem_req=1, iord=1, wait for mem_ready; ->MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-009 MEM_WR: mem_req=1, mem_we=1, iord=1, wait for mem_ready; ->FETCH.
REQ-010 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-011 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; ->I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-012 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH. JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-013 All outputs not listed for a state SHALL be 0; outputs are Moore except ir_write/pc_write in FETCH, which are gated by mem_ready.
REQ-014 run_en=0 SHALL freeze state, counters and all write strobes (pc_write, pc_write_cond, ir_write, reg_write, mem_we forced 0); mem_req held at its current value.
REQ-015 Wait counter SHALL clear on entry to any mem-wait state, increment each stalled cycle; reaching MEM_TIMEOUT without mem_ready -> FAULT, fault=1.
REQ-016 mem_ready asserted in a non-wait state SHALL be ignored.
REQ-017 FAULT SHALL be absorbing (all strobes 0) until SYS_reset.
REQ-018 cycle_count SHALL increment every cycle with run_en=1 outside IDLE/FAULT; instr_count SHALL increment on each transition into FETCH from a completion state; both wrap modulo 2^CNT_W.

Reset
REQ-019 SYS_reset=1 at a clock edge SHALL force IDLE, all strobes 0, fault=0, illegal=0, counters 0, wait counter 0; takes priority over run_en and mid-instruction states.

Structure
REQ-020 State encodings, opcode constants and alu_op/pc_source codes SHALL live in shared package mc_pkg.
REQ-021 One sub-module, mc_wait_timer (wait counter plus timeout compare), SHALL be instantiated; decode and output logic stay in multicycle_ctrl.

Verification
REQ-022 R-type (OpCode=0), mem_ready=1 in FETCH: states 1,2,7,8,1; reg_write=1, reg_dst=1 only in state 8; instr_count=1.
REQ-023 lw with mem_ready delayed 3 cycles in MEM_RD: stays in state 4 for 4 cycles, then 5 with mem_to_reg=1; no fault.
REQ-024 beq with zero=1: state 9 shows pc_write_cond=1, pc_source=01, alu_op=01; j: state 10 shows pc_write=1, pc_source=10.
REQ-025 OpCode=111111 in DECODE -> state 15, illegal=1, fault=0; stays in 15 with all strobes 0 until reset; with EN_ADDI=0, OpCode=001000 also -> 15.
REQ-026 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, fault=1.
REQ-027 run_en=0 for 5 cycles in R_EXEC then reset mid-instruction: state and counters frozen during hold; after reset state_out=0, counters 0, flags 0.
